tt_um_taghreed_eialsalman_tdm_demux: RTL and testbench
======================================================

// Module: tt_um_taghreed_eialsalman_tdm_demux
// PURPOSE
//  Receive-side counterpart of the 2:1 mux: a 1:2 time-division demultiplexer.
//  Accepts a slot-interleaved 4-bit stream (A,B,A,B,...) with a frame-sync flag
//  marking each channel-A slot. Routes each slot into per-channel holding
//  registers. Tracks frame lock, counts completed frames and flags sync errors.
//  Sits as a Tiny Tapeout user top level, driven directly from the pads.
// PARAMETERS
//  DW     4   data width per slot; fixed to 4 by pad budget
//  CNT_W  4   frame counter width; wraps modulo 2**CNT_W
// PORTS
//  clk      in   1  system clock; all logic on its rising edge
//  rst_n    in   1  synchronous reset, active low
//  ena      in   1  design enable; when low, state and all outputs hold
//  ui_in    in   8  [3:0] slot data, [4] slot_valid, [5] frame_sync, [7:6] unused
//  uio_in   in   8  unused (ignored)
//  uo_out   out  8  [3:0] chan_a data, [7:4] chan_b data
//  uio_out  out  8  [0] strobe_a, [1] strobe_b, [2] sync_err, [3] locked, [7:4] frame_cnt
//  uio_oe   out  8  constant 8'hFF (all uio pins are outputs)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): uo_out=0, uio_out=0, state=HUNT. uio_oe=8'hFF always.
//  - Reset mid-frame aborts the frame: no strobes, frame_cnt=0, relock needed.
//  - A slot is accepted on a clk edge when ena=1 and slot_valid=1; else ignored.
//  - All outputs are registered: an accepted slot updates outputs 1 cycle later.
//  - strobe_a, strobe_b and sync_err are 1-cycle pulses; they are 0 in cycles
//    without an accepted slot, including ena=0 cycles.
//  - States: HUNT (unlocked), WAIT_B (A received), WAIT_A (frame done).
//  - locked = (state != HUNT).
//  - HUNT: sync=1 -> chan_a<=data, strobe_a, go WAIT_B.
//          sync=0 -> slot discarded, stay HUNT, no error.
//  - WAIT_B: sync=0 -> chan_b<=data, strobe_b, frame_cnt+=1 (wraps 15->0), go WAIT_A.
//            sync=1 -> sync_err pulse; slot taken as new A (chan_a<=data, strobe_a);
//            stay WAIT_B; frame_cnt unchanged.
//  - WAIT_A: sync=1 -> chan_a<=data, strobe_a, go WAIT_B.
//            sync=0 -> sync_err pulse; slot discarded; chan_a/chan_b hold; go HUNT.
//  - chan_a/chan_b hold last value until overwritten; never cleared except by reset.
//  - ena=0: no state change, no register update, pulses deasserted. Resume exactly.
//  - ui_in[7:6] and uio_in have no effect in any state.
// TESTING
//  1 Reset: rst_n=0 for 2 clk -> uo_out=0, uio_out=0, uio_oe=8'hFF.
//  2 Frame: valid slots (sync=1,0x3), (sync=0,0xC) -> uo_out=8'hC3;
//    strobe_a then strobe_b, one cycle each; locked=1; frame_cnt=1.
//  3 Wrap: 16 good frames from reset -> frame_cnt=0, locked=1.
//    17th frame -> frame_cnt=1.
//  4 Double sync: (1,0x5),(1,0x6),(0,0x9) -> sync_err on 2nd slot;
//    uo_out=8'h96; frame_cnt=1.
//  5 Missing sync after frame: (1,0x1),(0,0x2),(0,0x7) -> sync_err, locked=0;
//    uo_out stays 8'h21. Next (1,0x4) relocks.
//  6 Gating: ena=0 or valid=0 with data toggling -> outputs frozen, no pulses.
//    Then rst_n=0 mid-frame after an A slot -> all outputs 0, state HUNT.

Source files
------------

// File: rtl/tt_um_taghreed_eialsalman_tdm_demux.sv
// 1:2 TDM demultiplexer: splits an A,B slot stream into two held channels,
// tracking frame lock, completed-frame count and sync errors.
module tdm_chan_reg #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_q
);
  logic [DW-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_q <= '0;
    else if (i_load) r_q <= i_data;
  end

  assign o_q = r_q;
endmodule

module tt_um_taghreed_eialsalman_tdm_demux #(
  parameter int DW    = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int NUM_CH = 2;

  typedef enum logic [1:0] {HUNT, WAIT_B, WAIT_A} state_t;

  state_t                      r_state, w_state_nxt;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_stb_a, r_stb_b, r_err;
  logic                        w_acc, w_sync, w_err, w_inc;
  logic [NUM_CH-1:0]           w_load;
  logic [NUM_CH-1:0][DW-1:0]   w_chan;
  logic [DW-1:0]               w_data;
  logic                        w_unused;

  assign w_data   = ui_in[DW-1:0];
  assign w_acc    = ena & ui_in[4];
  assign w_sync   = ui_in[5];
  assign w_unused = &{1'b0, ui_in[7:6], uio_in};

  // Every decision is qualified by an accepted slot, so idle or disabled
  // cycles leave the state alone and produce no pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = '0;
    w_err       = 1'b0;
    w_inc       = 1'b0;
    if (w_acc) begin
      case (r_state)
        HUNT: if (w_sync) begin
          w_load[0]   = 1'b1;
          w_state_nxt = WAIT_B;
        end
        WAIT_B: if (w_sync) begin
          w_err     = 1'b1;
          w_load[0] = 1'b1;
        end else begin
          w_load[1]   = 1'b1;
          w_inc       = 1'b1;
          w_state_nxt = WAIT_A;
        end
        WAIT_A: if (w_sync) begin
          w_load[0]   = 1'b1;
          w_state_nxt = WAIT_B;
        end else begin
          w_err       = 1'b1;
          w_state_nxt = HUNT;
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_cnt   <= '0;
      r_stb_a <= 1'b0;
      r_stb_b <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_stb_a <= w_load[0];
      r_stb_b <= w_load[1];
      r_err   <= w_err;
      if (w_inc) r_cnt <= r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    tdm_chan_reg #(.DW(DW)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load[g]),
      .i_data (w_data),
      .o_q    (w_chan[g])
    );
  end

  assign uo_out  = {w_chan[1], w_chan[0]};
  assign uio_out = {r_cnt, (r_state != HUNT), r_err, r_stb_b, r_stb_a};
  assign uio_oe  = 8'hFF;
endmodule

// File: tb/tb_tt_um_taghreed_eialsalman_tdm_demux.sv
// Randomized and directed bench for the TDM demux against a slot-level model.
module tb_tt_um_taghreed_eialsalman_tdm_demux;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = no lock, 1 = A seen and B owed, 2 = full frame seen.
  int       m_phase = 0;
  bit [3:0] m_a = 0, m_b = 0;
  int       m_cnt = 0;
  bit       m_sa = 0, m_sb = 0, m_err = 0;

  tt_um_taghreed_eialsalman_tdm_demux dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic bit [7:0] exp_uo();
    return {m_b, m_a};
  endfunction

  function automatic bit [7:0] exp_uio();
    bit [3:0] c;
    c = 4'(m_cnt % 16);
    return {c, (m_phase != 0), m_err, m_sb, m_sa};
  endfunction

  task automatic model_step(input bit r, input bit e, input bit v, input bit s, input bit [3:0] d);
    m_sa = 0; m_sb = 0; m_err = 0;
    if (!r) begin
      m_a = 0; m_b = 0; m_cnt = 0; m_phase = 0;
    end else if (e && v) begin
      if (m_phase == 0) begin
        if (s) begin m_a = d; m_sa = 1; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (s) begin m_err = 1; m_a = d; m_sa = 1; end
        else begin m_b = d; m_sb = 1; m_cnt = (m_cnt + 1) % 16; m_phase = 2; end
      end else begin
        if (s) begin m_a = d; m_sa = 1; m_phase = 1; end
        else begin m_err = 1; m_phase = 0; end
      end
    end
  endtask

  // One clock: drive at the falling edge with random junk on ignored pins,
  // then let the model advance and sample 1 time unit after the rising edge.
  task automatic cyc(input bit r, input bit e, input bit v, input bit s, input bit [3:0] d);
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = {2'($urandom), s, v, d};
    uio_in = 8'($urandom);
    @(posedge clk);
    #1;
    model_step(r, e, v, s, d);
  endtask

  task automatic test_reset();
    cyc(0, 1, 1, 1, 4'hF);
    cyc(0, 1, 1, 0, 4'hA);
    checks++;
    if ({uo_out, uio_out, uio_oe} !== 24'h0000FF) begin
      errors++;
      $display("FAIL reset: got %h/%h/%h want 00/00/ff", uo_out, uio_out, uio_oe);
    end
  endtask

  task automatic test_frame();
    cyc(1, 1, 1, 1, 4'h3);
    checks++;
    if (uio_out[1:0] !== 2'b01 || uo_out[3:0] !== 4'h3) begin
      errors++;
      $display("FAIL frame_a: got uo=%h uio=%h want strobe_a and chan_a=3", uo_out, uio_out);
    end
    cyc(1, 1, 1, 0, 4'hC);
    checks++;
    if (uo_out !== 8'hC3 || uio_out !== {4'd1, 4'b1010}) begin
      errors++;
      $display("FAIL frame_b: got uo=%h uio=%h want c3/1a", uo_out, uio_out);
    end
    cyc(1, 1, 0, 1, 4'h0);
    checks++;
    if (uio_out !== 8'h18 || uo_out !== exp_uo()) begin
      errors++;
      $display("FAIL frame_idle: got uo=%h uio=%h want %h/18", uo_out, uio_out, exp_uo());
    end
  endtask

  task automatic test_wrap();
    cyc(0, 1, 0, 0, 0);
    for (int f = 0; f < 17; f++) begin
      cyc(1, 1, 1, 1, 4'($urandom));
      cyc(1, 1, 1, 0, 4'($urandom));
      checks++;
      if (uo_out !== exp_uo() || uio_out !== exp_uio()) begin
        errors++;
        $display("FAIL wrap_f%0d: got %h/%h want %h/%h", f, uo_out, uio_out, exp_uo(), exp_uio());
      end
      if (f == 15) begin
        checks++;
        if (uio_out[7:3] !== 5'b00001) begin
          errors++;
          $display("FAIL wrap16: got cnt/lock %b want 00001", uio_out[7:3]);
        end
      end
    end
    checks++;
    if (uio_out[7:4] !== 4'd1) begin
      errors++;
      $display("FAIL wrap17: got cnt %0d want 1", uio_out[7:4]);
    end
  endtask

  task automatic test_double_sync();
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 4'h5);
    cyc(1, 1, 1, 1, 4'h6);
    checks++;
    if (uio_out[3:0] !== 4'b1101 || uo_out[3:0] !== 4'h6) begin
      errors++;
      $display("FAIL dsync_err: got uo=%h uio=%h want err+strobe_a, chan_a=6", uo_out, uio_out);
    end
    cyc(1, 1, 1, 0, 4'h9);
    checks++;
    if (uo_out !== 8'h96 || uio_out !== 8'h1A) begin
      errors++;
      $display("FAIL dsync_end: got %h/%h want 96/1a", uo_out, uio_out);
    end
  endtask

  task automatic test_missing_sync();
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 4'h1);
    cyc(1, 1, 1, 0, 4'h2);
    cyc(1, 1, 1, 0, 4'h7);
    checks++;
    if (uo_out !== 8'h21 || uio_out !== 8'h14) begin
      errors++;
      $display("FAIL msync: got %h/%h want 21/14", uo_out, uio_out);
    end
    cyc(1, 1, 1, 1, 4'h4);
    checks++;
    if (uo_out !== 8'h24 || uio_out !== 8'h19) begin
      errors++;
      $display("FAIL relock: got %h/%h want 24/19", uo_out, uio_out);
    end
  endtask

  task automatic test_gating();
    bit [7:0] uo0, uio0;
    cyc(1, 1, 1, 1, 4'hB);
    uo0  = uo_out;
    uio0 = uio_out & 8'hF8;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) cyc(1, 0, 1, 1'($urandom), 4'($urandom));
      else            cyc(1, 1, 0, 1'($urandom), 4'($urandom));
      checks++;
      if (uo_out !== uo0 || uio_out !== uio0 || uio_out !== exp_uio()) begin
        errors++;
        $display("FAIL gate_%0d: got %h/%h want %h/%h", i, uo_out, uio_out, uo0, uio0);
      end
    end
    cyc(1, 1, 1, 1, 4'hE);
    cyc(0, 1, 1, 0, 4'h3);
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: got %h/%h want 00/00", uo_out, uio_out);
    end
    cyc(1, 1, 1, 0, 4'h5);
    checks++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL rst_hunt: got %h/%h want 00/00", uo_out, uio_out);
    end
  endtask

  task automatic test_random();
    bit r, e, v, s;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) >= 2);
      e = ($urandom_range(0, 9) != 0);
      v = ($urandom_range(0, 9) >= 2);
      if ($urandom_range(0, 9) >= 2) s = (m_phase != 1);
      else                          s = 1'($urandom);
      cyc(r, e, v, s, 4'($urandom));
      checks++;
      if (uo_out !== exp_uo() || uio_out !== exp_uio() || uio_oe !== 8'hFF) begin
        errors++;
        $display("FAIL rand_%0d: got %h/%h/%h want %h/%h/ff", i, uo_out, uio_out, uio_oe,
                 exp_uo(), exp_uio());
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_wrap();
    test_double_sync();
    test_missing_sync();
    test_gating();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
